// File: rtl/priv_1_12_hpm.sv
// HPM counter bank: mhpmcounterN/h, mhpmeventN and user hpmcounterN/h shadows.
// Optional overflow flag (mhpmevent[31]) and ovf_irq under `HPM_OVERFLOW_IRQ_EN.

module priv_1_12_hpm_ctr #(
    parameter int NUM_EVENTS    = 8,
    parameter int COUNTER_WIDTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_lo,
    input  logic                     i_wr_hi,
    input  logic                     i_wr_ev,
    input  logic [31:0]              i_wdata,
    input  logic [NUM_EVENTS-1:0]    i_event,
    input  logic                     i_inhibit,
    output logic [COUNTER_WIDTH-1:0] o_cnt,
    output logic [7:0]               o_sel,
    output logic                     o_of
);
    localparam int HW = COUNTER_WIDTH - 32;

    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic [7:0]               r_sel;
    logic                     w_evt;
    logic                     w_inc;
    logic [7:0]               w_sel_wr;

    always_comb begin
        w_evt = 1'b0;
        for (int k = 1; k <= NUM_EVENTS; k++)
            if (r_sel == 8'(k)) w_evt = i_event[k-1];
    end

    // A software write to either half drops the increment entirely.
    assign w_inc    = w_evt & ~i_inhibit & ~i_wr_lo & ~i_wr_hi;
    assign w_sel_wr = (i_wdata[7:0] > 8'(NUM_EVENTS)) ? 8'd0 : i_wdata[7:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_sel <= '0;
        end else begin
            if (i_wr_lo)
                r_cnt[31:0] <= i_wdata;
            else if (i_wr_hi)
                r_cnt[COUNTER_WIDTH-1:32] <= i_wdata[HW-1:0];
            else if (w_inc)
                r_cnt <= r_cnt + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
            if (i_wr_ev)
                r_sel <= w_sel_wr;
        end
    end

`ifdef HPM_OVERFLOW_IRQ_EN
    logic r_of;
    logic w_wrap;
    assign w_wrap = w_inc & (&r_cnt);

    // Hardware set beats a same-cycle software clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_of <= 1'b0;
        else if (w_wrap)   r_of <= 1'b1;
        else if (i_wr_ev)  r_of <= i_wdata[31];
    end
    assign o_of = r_of;
`else
    assign o_of = 1'b0;
`endif

    assign o_cnt = r_cnt;
    assign o_sel = r_sel;
endmodule

module priv_1_12_hpm #(
    parameter int NUM_COUNTERS  = 4,
    parameter int NUM_EVENTS    = 8,
    parameter int COUNTER_WIDTH = 64
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [11:0]             csr_addr,
    input  logic                    csr_wen,
    input  logic [31:0]             csr_wdata,
    output logic [31:0]             csr_rdata,
    output logic                    csr_hit,
    output logic                    csr_fault,
    input  logic [1:0]              curr_priv,
    input  logic [NUM_COUNTERS-1:0] mcounteren_hpm,
    input  logic [NUM_COUNTERS-1:0] mcountinhibit_hpm,
    input  logic [NUM_EVENTS-1:0]   event_in,
    output logic                    ovf_irq
);
    localparam logic [5:0] NC6 = 6'(NUM_COUNTERS);

    logic [NUM_COUNTERS-1:0][COUNTER_WIDTH-1:0] w_cnt;
    logic [NUM_COUNTERS-1:0][7:0]               w_sel;
    logic [NUM_COUNTERS-1:0]                    w_of;

    logic [6:0]  w_grp;
    logic [4:0]  w_idx;
    logic        w_idx_ok;
    logic        w_m_lo, w_m_hi, w_m_ev, w_u_lo, w_u_hi, w_m, w_u;
    logic        w_we;
    logic [63:0] w_rd_cnt;
    logic [7:0]  w_rd_sel;
    logic        w_rd_of;
    logic        w_rd_en;

    // Each CSR group occupies one 32-entry block; the low 5 bits are 3+i.
    assign w_grp    = csr_addr[11:5];
    assign w_idx    = csr_addr[4:0] - 5'd3;
    assign w_idx_ok = (csr_addr[4:0] >= 5'd3) && ({1'b0, w_idx} < NC6);

    assign w_m_lo = (w_grp == 7'h58);
    assign w_m_hi = (w_grp == 7'h5C);
    assign w_m_ev = (w_grp == 7'h19);
    assign w_u_lo = (w_grp == 7'h60);
    assign w_u_hi = (w_grp == 7'h64);
    assign w_m    = w_m_lo | w_m_hi | w_m_ev;
    assign w_u    = w_u_lo | w_u_hi;

    always_comb begin
        w_rd_cnt = '0;
        w_rd_sel = '0;
        w_rd_of  = 1'b0;
        w_rd_en  = 1'b0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (w_idx == 5'(i)) begin
                w_rd_cnt = 64'(w_cnt[i]);
                w_rd_sel = w_sel[i];
                w_rd_of  = w_of[i];
                w_rd_en  = mcounteren_hpm[i];
            end
        end
    end

    assign csr_hit   = w_idx_ok & (w_m | w_u);
    assign csr_fault = csr_hit & ((w_m & (curr_priv != 2'b11)) |
                                  (w_u & (csr_wen | ((curr_priv != 2'b11) & ~w_rd_en))));
    assign w_we      = csr_wen & csr_hit & ~csr_fault;

    always_comb begin
        csr_rdata = '0;
        if (csr_hit) begin
            if (w_m_lo | w_u_lo)      csr_rdata = w_rd_cnt[31:0];
            else if (w_m_hi | w_u_hi) csr_rdata = w_rd_cnt[63:32];
            else                      csr_rdata = {w_rd_of, 23'd0, w_rd_sel};
        end
    end

    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_ctr
        logic w_sel_me;
        assign w_sel_me = w_we & (w_idx == 5'(g));
        priv_1_12_hpm_ctr #(
            .NUM_EVENTS   (NUM_EVENTS),
            .COUNTER_WIDTH(COUNTER_WIDTH)
        ) u_ctr (
            .i_clk    (CLK),
            .i_rst_n  (nRST),
            .i_wr_lo  (w_sel_me & w_m_lo),
            .i_wr_hi  (w_sel_me & w_m_hi),
            .i_wr_ev  (w_sel_me & w_m_ev),
            .i_wdata  (csr_wdata),
            .i_event  (event_in),
            .i_inhibit(mcountinhibit_hpm[g]),
            .o_cnt    (w_cnt[g]),
            .o_sel    (w_sel[g]),
            .o_of     (w_of[g])
        );
    end

`ifdef HPM_OVERFLOW_IRQ_EN
    logic r_ovf_irq;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_ovf_irq <= 1'b0;
        else       r_ovf_irq <= |w_of;
    end
    assign ovf_irq = r_ovf_irq;
`else
    logic w_unused_of;
    assign w_unused_of = |w_of;
    assign ovf_irq     = 1'b0;
`endif
endmodule
